// File: rtl/stopwatch_display.sv
// stopwatch_display: converts a tenths-of-second count (0..9999) to four BCD
// digits with a sequential shift-add-3 engine and scans them onto a
// common-anode 4-digit 7-segment display as "XXX.X".
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits in the
// hundreds/tens-of-seconds positions (never while overflow is shown).
module stopwatch_display #(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_DIV = CLK_HZ / 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        busy,
  output logic        ovf
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [31:0]   MAX_VAL   = 32'd9999;
  localparam logic [3:0]    LAST_ITER = 4'd13;
  localparam logic [6:0]    SEG_DASH  = 7'h3F;
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Active-low gfedcba code for one BCD digit; non-decimal nibbles render blank.
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Add 3 to every nibble that is 5 or more, ahead of the doubling shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic           load_s, step_s, latch_s;
  logic [31:0]    last_value_q, last_value_d;
  logic [15:0]    bcd_q, bcd_d, bcd_adj_s;
  logic [13:0]    bin_q, bin_d;
  logic [3:0]     iter_q, iter_d;
  logic           ovf_pend_q, ovf_pend_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    digits_q, digits_d;
  logic [CW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]     digit_idx_q, digit_idx_d;
  logic           scan_wrap_s;
  logic [3:0]     nib_s;
  logic           blank_s;
  logic [6:0]     seg_q, seg_d, seg_new_s;
  logic           dp_q, dp_d;
  logic [3:0]     an_q, an_d;

  // Conversion FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Conversion FSM next-state: start on a new value, 14 iterations, one latch cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (value != last_value_q) begin
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (iter_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion FSM outputs: datapath strobes decoded from the state.
  always_comb begin
    load_s  = 1'b0;
    step_s  = 1'b0;
    latch_s = 1'b0;
    case (state_q)
      S_IDLE:  load_s  = (value != last_value_q);
      S_CONV:  step_s  = 1'b1;
      S_DONE:  latch_s = 1'b1;
      default: load_s  = 1'b0;
    endcase
  end

  assign bcd_adj_s = bcd_adjust(bcd_q);

  // Conversion datapath next-state: capture, shift-add-3 iteration, result latch.
  always_comb begin
    last_value_d = last_value_q;
    bcd_d        = bcd_q;
    bin_d        = bin_q;
    iter_d       = iter_q;
    ovf_pend_d   = ovf_pend_q;
    busy_d       = busy_q;
    digits_d     = digits_q;
    ovf_d        = ovf_q;
    if (load_s) begin
      last_value_d = value;
      bin_d        = value[13:0];
      bcd_d        = 16'h0000;
      ovf_pend_d   = (value > MAX_VAL);
      busy_d       = 1'b1;
      iter_d       = 4'd0;
    end else if (step_s) begin
      bcd_d  = {bcd_adj_s[14:0], bin_q[13]};
      bin_d  = {bin_q[12:0], 1'b0};
      iter_d = iter_q + 4'd1;
    end else if (latch_s) begin
      digits_d = bcd_q;
      ovf_d    = ovf_pend_q;
      busy_d   = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // Conversion datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_value_q <= 32'd0;
      bcd_q        <= 16'h0000;
      bin_q        <= 14'd0;
      iter_q       <= 4'd0;
      ovf_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
      digits_q     <= 16'h0000;
      ovf_q        <= 1'b0;
    end else begin
      last_value_q <= last_value_d;
      bcd_q        <= bcd_d;
      bin_q        <= bin_d;
      iter_q       <= iter_d;
      ovf_pend_q   <= ovf_pend_d;
      busy_q       <= busy_d;
      digits_q     <= digits_d;
      ovf_q        <= ovf_d;
    end
  end

  // Scan next-state: on each counter wrap pick the next digit and render it.
  always_comb begin
    scan_wrap_s = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = scan_cnt_q + CW'(1);
    digit_idx_d = digit_idx_q;
    if (scan_wrap_s) begin
      scan_cnt_d  = '0;
      digit_idx_d = digit_idx_q + 2'd1;
    end else begin
      digit_idx_d = digit_idx_q;
    end
    nib_s = digits_q[{digit_idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank_s = ((digit_idx_d == 2'd3) && (digits_q[15:12] == 4'd0)) ||
              ((digit_idx_d == 2'd2) && (digits_q[15:8] == 8'd0));
`else
    blank_s = 1'b0;
`endif
    if (ovf_q) begin
      seg_new_s = SEG_DASH;
    end else if (blank_s) begin
      seg_new_s = SEG_BLANK;
    end else begin
      seg_new_s = seg_code(nib_s);
    end
    seg_d = seg_q;
    dp_d  = dp_q;
    an_d  = an_q;
    if (scan_wrap_s) begin
      seg_d = seg_new_s;
      dp_d  = ~((digit_idx_d == 2'd1) && !ovf_q);
      an_d  = ~(4'b0001 << digit_idx_d);
    end else begin
      seg_d = seg_q;
    end
  end

  // Scan registers and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= 2'd0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      an_q        <= 4'hF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Consumer end of the stopwatch count bus.
- Takes the 32-bit tenths-of-second count (range 0..9999) produced by the stopwatch.
- Converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a time-multiplexed 4-digit common-anode 7-segment display showing "XXX.X".

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCAN_DIV, CLK_HZ/4000, clock cycles each digit stays lit. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- value  input  32  count to display, in tenths of a second; synchronous to clk.
- seg  output  7  segments, active-low; bit0=a … bit6=g.
- dp  output  1  decimal point, active-low.
- an  output  4  digit enables, active-low; an[0]=tenths … an[3]=hundreds of seconds.
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high while the latched value exceeded 9999.

Behaviour:
- Reset (async): seg=7'h7F, dp=1, an=4'hF, busy=0, ovf=0, digit regs=0, last_value=0, FSM=IDLE, scan counter=0, digit index=0.
- FSM states: IDLE, CONV, DONE.
- IDLE: on an edge where value != last_value:
  - capture value into last_value and into the shift register (low 14 bits);
  - set ovf_pending = (value > 9999), computed on all 32 bits;
  - busy<=1, iter<=0, go CONV.
  - Otherwise stay in IDLE.
- CONV: each cycle performs one iteration:
  - add 3 to every BCD nibble ≥5;
  - then shift {bcd, bin} left by 1.
  - After exactly 14 iterations go DONE.
- DONE:
  - latch the BCD nibbles into the digit regs;
  - ovf<=ovf_pending;
  - busy<=0, go IDLE.
- Latency: capture edge E0, iterations on E1..E14, digit regs and ovf update on E15. busy is high from after E0 through E15.
- value changes during CONV/DONE are ignored. IDLE re-compares on the cycle after DONE, so the final value always converges. value never written back.
- Overflow: when ovf=1, all four digits display dash (seg=7'h3F) and dp stays off. Conversion still runs full length; the latency is unchanged.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - On each wrap the digit index advances 0→1→2→3→0, and seg/an/dp are registered for the new index.
  - Exactly one an bit is low once scanning starts.
  - First active digit is index 1, appearing SCAN_DIV cycles after reset release; an is all-off before that.
- dp is low only while an[1] is active and ovf=0 (renders "XXX.X").
- Segment codes (active-low, gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 dash=3F blank=7F (hex).
- Reset mid-conversion: immediate return to reset values; the partial result is discarded.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined:
  - digit 3 shows blank (7F) when it is 0;
  - digit 2 shows blank when digits 3 and 2 are both 0;
  - digits 1 and 0 are never blanked, so 0 shows "  0.0".
- Not defined: all four digits are always shown, so 0 shows "000.0".
- Blanking never applies while ovf=1.

Test Plan:
- Reset, SCAN_DIV=4, value=0: an=F, seg=7F, busy=0 until cycle 4, then an=D, seg=40, dp=0. Subsequent an sequence: B, 7, E, D…
- value 0→1234 at E0: busy high for E1..E15. Digit regs = 1,2,3,4 after E15. Scan shows an=E seg=19, an=D seg=30 dp=0, an=B seg=24, an=7 seg=79.
- value=10000: after 15 cycles ovf=1, all digits seg=3F, dp=1. Then value=9999: ovf=0, digits 9,9,9,9.
- value 1234, then changed to 5678 at E5 (mid-CONV): display first becomes 1234 at E15. IDLE recaptures 5678 at E16, and the display shows 5678 at E31.
- Assert rst at E7 of a conversion: outputs return to reset values immediately and the digit regs stay 0. After release, the same value is reconverted.
- Value 5 with LEADING_ZERO_BLANK_EN defined: an[3], an[2] slots show 7F, an[1] shows 40 with dp=0, an[0] shows 12. Without the macro, an[3] and an[2] show 40.
